// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// Shared constants and FSM encoding for the EtherNeco sync-timer master.
// Byte positions refer to the command frame and the returned response frame.
package jellyvl_etherneco_synctimer_pkg;

  localparam logic [15:0] CMD_POS     = 16'd0;
  localparam logic [15:0] TIME_POS    = 16'd1;
  localparam logic [15:0] TIME_END    = 16'd8;
  localparam logic [15:0] OFFSET_POS  = 16'd9;
  localparam logic [15:0] OFFSET_END  = 16'd12;
  localparam logic [15:0] CMD_LEN     = 16'd13;
  localparam logic [15:0] NODE_BASE   = 16'd9;
  localparam logic [15:0] NODE_STRIDE = 16'd4;

  localparam int CMD_BIT_VALID    = 0;
  localparam int CMD_BIT_OVERRIDE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_REQ,
    ST_CMD_WAIT,
    ST_RES_REQ,
    ST_RES_WAIT
  } state_t;

endpackage

// File: rtl/jellyvl_etherneco_synctimer_master_collect.sv
// Shadow capture of returned per-node elapsed times.
// Commits atomically on an error-free frame end.
module jellyvl_etherneco_synctimer_master_collect
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int NODE_NUM = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  active_i,
  input  logic                  rx_start_i,
  input  logic                  rx_end_i,
  input  logic                  rx_error_i,
  input  logic [15:0]           pos_i,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic                  good_o,
  output logic                  bad_o,
  output logic [NODE_NUM*32-1:0] elapsed_o
);

  logic [NODE_NUM*32-1:0] shadow_q, shadow_d;
  logic [NODE_NUM*32-1:0] elapsed_q;
  logic                   err_q, err_d;

  // same-cycle byte and end are merged before the commit decision
  always_comb begin
    shadow_d = shadow_q;
    err_d    = err_q;
    if (active_i && rx_start_i) begin
      shadow_d = '0;
      err_d    = 1'b0;
    end
    if (active_i && rx_error_i) begin
      err_d = 1'b1;
    end
    if (active_i && valid_i) begin
      for (int n = 0; n < NODE_NUM; n++) begin
        for (int k = 0; k < 4; k++) begin
          if (pos_i == NODE_BASE + NODE_STRIDE * 16'(n) + 16'(k)) begin
            shadow_d[32*n+8*k +: 8] = data_i;
          end
        end
      end
    end
  end

  assign good_o    = active_i && rx_end_i && !err_d;
  assign bad_o     = active_i && rx_end_i && err_d;
  assign elapsed_o = elapsed_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= '0;
      err_q     <= 1'b0;
      elapsed_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
      if (good_o) begin
        elapsed_q <= shadow_d;
      end
    end
  end

endmodule

// File: rtl/jellyvl_etherneco_synctimer_master.sv
// EtherNeco sync-timer ring master: command/response launch and capture.
// Define JELLYVL_SYNCTIMER_MASTER_OFFSET_EN to build offset measurement.
module jellyvl_etherneco_synctimer_master
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH   = 64,
  parameter int NODE_NUM      = 4,
  parameter int PERIOD_WIDTH  = 32,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [PERIOD_WIDTH-1:0]  param_period,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  input  logic [TIMER_WIDTH-1:0]   current_time,
  output logic                     cmd_tx_start,
  output logic [15:0]              cmd_tx_length,
  input  logic                     cmd_tx_end,
  input  logic [15:0]              s_cmd_pos,
  input  logic                     s_cmd_valid,
  output logic [7:0]               m_cmd_data,
  output logic                     m_cmd_valid,
  output logic                     res_tx_start,
  output logic [15:0]              res_tx_length,
  input  logic                     res_tx_end,
  input  logic [15:0]              s_restx_pos,
  input  logic                     s_restx_valid,
  output logic [7:0]               m_restx_data,
  output logic                     m_restx_valid,
  input  logic                     res_rx_start,
  input  logic                     res_rx_end,
  input  logic                     res_rx_error,
  input  logic [15:0]              s_res_pos,
  input  logic [7:0]               s_res_data,
  input  logic                     s_res_valid,
  output logic [NODE_NUM*32-1:0]   elapsed,
  output logic                     sync_done,
  output logic                     sync_timeout
);

  localparam logic [15:0] RES_LEN = 16'(9 + 4 * NODE_NUM);

  state_t                   state_q;
  logic [PERIOD_WIDTH-1:0]  pcnt_q, pmax;
  logic [TIMEOUT_WIDTH-1:0] tcnt_q;
  logic [TIMER_WIDTH-1:0]   tx_time_q;
  logic [31:0]              offset;
  logic                     override_q;
  logic                     cmd_start_q, res_start_q;
  logic                     done_q, tout_q;
  logic [7:0]               cmd_data_q, cmd_byte;
  logic                     cmd_valid_q, restx_valid_q;
  logic                     good, bad, tout_hit;
  logic [2:0]               tidx;
  logic [1:0]               oidx;

  assign pmax = (param_period == '0) ? '0
              : param_period - PERIOD_WIDTH'(1);

  // timeout fires after param_timeout cycles spent in RES_WAIT
  assign tout_hit = (param_timeout == '0)
                 || (tcnt_q + TIMEOUT_WIDTH'(1) == param_timeout);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
    end else if (pcnt_q >= pmax) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      tx_time_q   <= '0;
      override_q  <= 1'b1;
      cmd_start_q <= 1'b0;
      res_start_q <= 1'b0;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      cmd_start_q <= 1'b0;
      res_start_q <= 1'b0;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (enable && pcnt_q >= pmax) begin
            tx_time_q   <= current_time;
            cmd_start_q <= 1'b1;
            state_q     <= ST_CMD_REQ;
          end
        end
        ST_CMD_REQ: begin
          state_q <= ST_CMD_WAIT;
        end
        ST_CMD_WAIT: begin
          if (cmd_tx_end) begin
            override_q  <= 1'b0;
            res_start_q <= 1'b1;
            state_q     <= ST_RES_REQ;
          end
        end
        ST_RES_REQ: begin
          tcnt_q  <= '0;
          state_q <= ST_RES_WAIT;
        end
        ST_RES_WAIT: begin
          tcnt_q <= tcnt_q + TIMEOUT_WIDTH'(1);
          if (good) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (bad || tout_hit) begin
            tout_q     <= 1'b1;
            override_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  jellyvl_etherneco_synctimer_master_collect #(
    .NODE_NUM (NODE_NUM)
  ) u_collect (
    .clk        (clk),
    .reset_n    (reset_n),
    .active_i   (state_q == ST_RES_WAIT),
    .rx_start_i (res_rx_start),
    .rx_end_i   (res_rx_end),
    .rx_error_i (res_rx_error),
    .pos_i      (s_res_pos),
    .data_i     (s_res_data),
    .valid_i    (s_res_valid),
    .good_o     (good),
    .bad_o      (bad),
    .elapsed_o  (elapsed)
  );

`ifdef JELLYVL_SYNCTIMER_MASTER_OFFSET_EN
  logic [31:0] offset_q;

  // half the node-1 round trip, taken once elapsed has committed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      offset_q <= '0;
    end else if (done_q) begin
      offset_q <= elapsed[31:0] >> 1;
    end
  end

  assign offset = offset_q;
`else
  assign offset = 32'h0;
`endif

  assign tidx = 3'(s_cmd_pos - TIME_POS);
  assign oidx = 2'(s_cmd_pos - OFFSET_POS);

  always_comb begin
    cmd_byte = 8'h00;
    unique case (1'b1)
      (s_cmd_pos == CMD_POS): begin
        cmd_byte[CMD_BIT_VALID]    = 1'b1;
        cmd_byte[CMD_BIT_OVERRIDE] = override_q;
      end
      (s_cmd_pos >= TIME_POS && s_cmd_pos <= TIME_END):
        cmd_byte = tx_time_q[{tidx, 3'b000} +: 8];
      (s_cmd_pos >= OFFSET_POS && s_cmd_pos <= OFFSET_END):
        cmd_byte = offset[{oidx, 3'b000} +: 8];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid_q   <= 1'b0;
      cmd_data_q    <= 8'h00;
      restx_valid_q <= 1'b0;
    end else begin
      cmd_valid_q   <= s_cmd_valid && (s_cmd_pos < CMD_LEN);
      cmd_data_q    <= (s_cmd_valid && s_cmd_pos < CMD_LEN)
                     ? cmd_byte : 8'h00;
      restx_valid_q <= s_restx_valid && (s_restx_pos < RES_LEN);
    end
  end

  logic unused_res_tx_end;
  assign unused_res_tx_end = res_tx_end;

  assign cmd_tx_start  = cmd_start_q;
  assign cmd_tx_length = CMD_LEN;
  assign m_cmd_data    = cmd_data_q;
  assign m_cmd_valid   = cmd_valid_q;
  assign res_tx_start  = res_start_q;
  assign res_tx_length = RES_LEN;
  assign m_restx_data  = 8'h00;
  assign m_restx_valid = restx_valid_q;
  assign sync_done     = done_q;
  assign sync_timeout  = tout_q;

endmodule
